// File: rtl/rob_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rob_ctrl
// Brief    : Reorder-buffer controller. It tracks allocate, complete, retire
//            and flush for ROB_DEPTH in-order entries. Head and tail pointers
//            carry a wrap bit so that the full and empty states are distinct.
// Option   : ROB_PERF_CNT_EN adds a 32-bit committed-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module rob_ctrl #(
  parameter int ROB_DEPTH = 16,
  parameter int ROB       = $clog2(ROB_DEPTH)
) (
  input  logic           clk,
  input  logic           reset_,
  input  logic           alloc_req,
  output logic           alloc_ack,
  output logic [ROB-1:0] alloc_id,
  input  logic           done_valid,
  input  logic [ROB-1:0] done_id,
  input  logic           done_exc,
  output logic           commit_valid,
  output logic [ROB-1:0] commit_id,
  output logic           commit_exc,
  input  logic           commit_ready,
  input  logic           flush_req,
  output logic           flush,
  output logic           full,
  output logic           empty,
  output logic [ROB:0]   count
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]    perf_commit_cnt
`endif
);

  localparam logic [ROB:0] c_PTR_ONE = {{ROB{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ROB:0]         r_head;
  logic [ROB:0]         r_tail;
  logic [ROB_DEPTH-1:0] r_done;
  logic [ROB_DEPTH-1:0] r_exc;

  logic [ROB-1:0]       w_head_idx;
  logic [ROB-1:0]       w_tail_idx;
  logic [ROB-1:0]       w_done_off;
  logic [ROB:0]         w_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_head_rdy;
  logic                 w_done_ok;
  logic                 w_commit_fire;

  assign w_head_idx = r_head[ROB-1:0];
  assign w_tail_idx = r_tail[ROB-1:0];
  assign w_count    = r_tail - r_head;
  assign w_empty    = (r_head == r_tail);
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[ROB] != r_tail[ROB]);
  assign w_head_rdy = ~w_empty & r_done[w_head_idx];

  // A completion is only meaningful for an occupied slot: its distance from
  // the head must be below the current occupancy. This also covers full.
  assign w_done_off = done_id - w_head_idx;
  assign w_done_ok  = done_valid && (r_state == ST_RUN) &&
                      ({1'b0, w_done_off} < w_count);

  assign w_commit_fire = commit_valid & commit_ready;

  assign alloc_id   = w_tail_idx;
  assign commit_id  = w_head_idx;
  assign commit_exc = r_exc[w_head_idx];
  assign full       = w_full;
  assign empty      = w_empty;
  assign count      = w_count;

  // State register.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs. FLUSH always lasts exactly one cycle,
  // so any flush_req seen while flushing is absorbed.
  always_comb begin
    w_state_nxt  = r_state;
    alloc_ack    = 1'b0;
    commit_valid = 1'b0;
    flush        = 1'b0;
    case (r_state)
      ST_RUN: begin
        alloc_ack    = alloc_req & ~w_full & ~flush_req;
        commit_valid = w_head_rdy;
        if (flush_req || (w_head_rdy && commit_ready && r_exc[w_head_idx])) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        flush       = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Head and tail pointers. The edge that leaves FLUSH empties the buffer.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (r_state == ST_FLUSH) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (alloc_ack) begin
        r_tail <= r_tail + c_PTR_ONE;
      end
      if (w_commit_fire) begin
        r_head <= r_head + c_PTR_ONE;
      end
    end
  end

  // Per-entry completion and exception flags. A fresh allocation clears its
  // slot. A live done cannot target the tail slot, so the two never collide.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      r_done <= '0;
      r_exc  <= '0;
    end else if (r_state == ST_FLUSH) begin
      r_done <= '0;
      r_exc  <= '0;
    end else begin
      if (alloc_ack) begin
        r_done[w_tail_idx] <= 1'b0;
        r_exc[w_tail_idx]  <= 1'b0;
      end
      if (w_done_ok) begin
        r_done[done_id] <= 1'b1;
        r_exc[done_id]  <= done_exc;
      end
    end
  end

`ifdef ROB_PERF_CNT_EN
  // Committed-instruction counter. It wraps naturally at 2^32.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      perf_commit_cnt <= '0;
    end else if (w_commit_fire) begin
      perf_commit_cnt <= perf_commit_cnt + 32'd1;
    end
  end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_rob_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_ctrl
// Brief    : Directed self-checking bench for rob_ctrl at ROB_DEPTH = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rob_ctrl;

  localparam int DEPTH = 4;
  localparam int W     = 2;

  logic         clk;
  logic         reset_;
  logic         alloc_req;
  logic         alloc_ack;
  logic [W-1:0] alloc_id;
  logic         done_valid;
  logic [W-1:0] done_id;
  logic         done_exc;
  logic         commit_valid;
  logic [W-1:0] commit_id;
  logic         commit_exc;
  logic         commit_ready;
  logic         flush_req;
  logic         flush;
  logic         full;
  logic         empty;
  logic [W:0]   count;
`ifdef ROB_PERF_CNT_EN
  logic [31:0]  perf_commit_cnt;
`endif

  int total = 0;
  int bad   = 0;

  rob_ctrl #(.ROB_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_       (reset_),
    .alloc_req    (alloc_req),
    .alloc_ack    (alloc_ack),
    .alloc_id     (alloc_id),
    .done_valid   (done_valid),
    .done_id      (done_id),
    .done_exc     (done_exc),
    .commit_valid (commit_valid),
    .commit_id    (commit_id),
    .commit_exc   (commit_exc),
    .commit_ready (commit_ready),
    .flush_req    (flush_req),
    .flush        (flush),
    .full         (full),
    .empty        (empty),
    .count        (count)
`ifdef ROB_PERF_CNT_EN
    ,
    .perf_commit_cnt (perf_commit_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_       = 1'b1;
    alloc_req    = 1'b0;
    done_valid   = 1'b0;
    done_id      = '0;
    done_exc     = 1'b0;
    commit_ready = 1'b0;
    flush_req    = 1'b0;

    // Reset state before any clock edge.
    #2;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_cvalid", 32'(commit_valid), 32'd0);
    chk("rst_cexc", 32'(commit_exc), 32'd0);
    chk("rst_aack", 32'(alloc_ack), 32'd0);
    chk("rst_aid", 32'(alloc_id), 32'd0);
    chk("rst_cid", 32'(commit_id), 32'd0);
    tick();
    reset_ = 1'b0;
    #1;

    // Fill: five requesting cycles, only four grants.
    alloc_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("fill_ack", 32'(alloc_ack), (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) chk("fill_id", 32'(alloc_id), 32'(i));
      tick();
    end
    alloc_req = 1'b0;
    #1;
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_ack_off", 32'(alloc_ack), 32'd0);

    // Out-of-order completion 2, 0, 1, then 3.
    commit_ready = 1'b1;
    done_valid = 1'b1; done_id = 2'd2; #1;
    chk("ooo_cv_a", 32'(commit_valid), 32'd0);
    tick();
    done_valid = 1'b0; #1;
    chk("ooo_cv_b", 32'(commit_valid), 32'd0);
    done_valid = 1'b1; done_id = 2'd0; #1;
    chk("ooo_cv_c", 32'(commit_valid), 32'd0);
    tick();
    done_valid = 1'b0; #1;
    chk("ooo_cv0", 32'(commit_valid), 32'd1);
    chk("ooo_cid0", 32'(commit_id), 32'd0);
    tick();
    done_valid = 1'b1; done_id = 2'd1; #1;
    chk("ooo_cv_d", 32'(commit_valid), 32'd0);
    chk("ooo_count3", 32'(count), 32'd3);
    tick();
    done_valid = 1'b0; #1;
    chk("ooo_cv1", 32'(commit_valid), 32'd1);
    chk("ooo_cid1", 32'(commit_id), 32'd1);
    tick();
    #1;
    chk("ooo_cv2", 32'(commit_valid), 32'd1);
    chk("ooo_cid2", 32'(commit_id), 32'd2);
    tick();
    done_valid = 1'b1; done_id = 2'd3;
    tick();
    done_valid = 1'b0; #1;
    chk("ooo_cid3", 32'(commit_id), 32'd3);
    tick();
    #1;
    chk("ooo_empty", 32'(empty), 32'd1);
    chk("ooo_count0", 32'(count), 32'd0);

    // Wrap: six alloc/complete/commit rounds starting at index 0.
    for (int k = 0; k < 6; k++) begin
      alloc_req = 1'b1; #1;
      chk("wrap_aid", 32'(alloc_id), 32'(k % DEPTH));
      chk("wrap_ack", 32'(alloc_ack), 32'd1);
      tick();
      alloc_req = 1'b0;
      done_valid = 1'b1; done_id = 2'(k % DEPTH);
      tick();
      done_valid = 1'b0; #1;
      chk("wrap_cid", 32'(commit_id), 32'(k % DEPTH));
      chk("wrap_count", 32'(count), 32'd1);
      tick();
    end
    #1;
    chk("wrap_empty", 32'(empty), 32'd1);

    // Flush request with alloc and commit in the same cycle (pointers at 2).
    commit_ready = 1'b0;
    alloc_req = 1'b1;
    tick();
    tick();
    alloc_req = 1'b0;
    done_valid = 1'b1; done_id = 2'd2;
    tick();
    done_valid = 1'b0;
    commit_ready = 1'b1; flush_req = 1'b1; alloc_req = 1'b1; #1;
    chk("fr_ack", 32'(alloc_ack), 32'd0);
    chk("fr_cv", 32'(commit_valid), 32'd1);
    chk("fr_cid", 32'(commit_id), 32'd2);
    tick();
    #1;
    chk("fr_flush", 32'(flush), 32'd1);
    chk("fr_ack_fl", 32'(alloc_ack), 32'd0);
    chk("fr_cv_fl", 32'(commit_valid), 32'd0);
    chk("fr_count", 32'(count), 32'd1);
    tick();
    flush_req = 1'b0; alloc_req = 1'b0; commit_ready = 1'b0; #1;
    chk("fr_flush_off", 32'(flush), 32'd0);
    chk("fr_empty", 32'(empty), 32'd1);
    chk("fr_aid0", 32'(alloc_id), 32'd0);
    chk("fr_cid0", 32'(commit_id), 32'd0);

    // Exception on entry 1.
    alloc_req = 1'b1;
    tick();
    tick();
    alloc_req = 1'b0;
    done_valid = 1'b1; done_id = 2'd1; done_exc = 1'b1;
    tick();
    done_id = 2'd0; done_exc = 1'b0;
    tick();
    done_valid = 1'b0; commit_ready = 1'b1; #1;
    chk("exc_cv0", 32'(commit_valid), 32'd1);
    chk("exc_cid0", 32'(commit_id), 32'd0);
    chk("exc_cexc0", 32'(commit_exc), 32'd0);
    tick();
    #1;
    chk("exc_cid1", 32'(commit_id), 32'd1);
    chk("exc_cexc1", 32'(commit_exc), 32'd1);
    tick();
    commit_ready = 1'b0; #1;
    chk("exc_flush", 32'(flush), 32'd1);
    chk("exc_cv_fl", 32'(commit_valid), 32'd0);
    tick();
    alloc_req = 1'b1; #1;
    chk("exc_flush_off", 32'(flush), 32'd0);
    chk("exc_count", 32'(count), 32'd0);
    chk("exc_aid", 32'(alloc_id), 32'd0);
    chk("exc_ack", 32'(alloc_ack), 32'd1);
    tick();

    // Simultaneous alloc and commit keeps count constant.
    alloc_req = 1'b0;
    done_valid = 1'b1; done_id = 2'd0;
    tick();
    done_valid = 1'b0; alloc_req = 1'b1; commit_ready = 1'b1; #1;
    chk("sim_cv", 32'(commit_valid), 32'd1);
    chk("sim_ack", 32'(alloc_ack), 32'd1);
    chk("sim_cnt_pre", 32'(count), 32'd1);
    tick();
    commit_ready = 1'b0; #1;
    chk("sim_cnt_post", 32'(count), 32'd1);
    chk("sim_aid", 32'(alloc_id), 32'd2);
    tick();
    tick();
    alloc_req = 1'b0; #1;
    chk("r39_count3", 32'(count), 32'd3);

    // Asynchronous reset while flushing with three entries held.
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0; #1;
    chk("r39_flush", 32'(flush), 32'd1);
    reset_ = 1'b1; #1;
    chk("r39_empty", 32'(empty), 32'd1);
    chk("r39_flush0", 32'(flush), 32'd0);
    chk("r39_count0", 32'(count), 32'd0);
    chk("r39_cv", 32'(commit_valid), 32'd0);
    tick();
    reset_ = 1'b0; #1;
    chk("r39_aid", 32'(alloc_id), 32'd0);
    chk("r39_empty2", 32'(empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rob_ctrl.md
ROB_CTRL -- requirements
Module: rob_ctrl

Interface
REQ-001 Parameter ROB_DEPTH, default 16, number of reorder-buffer entries; power of two, minimum 4.
REQ-002 Parameter ROB, default $clog2(ROB_DEPTH), entry index width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_  in  1  asynchronous, active-high reset.
REQ-005 alloc_req  in  1  decode requests one ROB entry.
REQ-006 alloc_ack  out  1  entry granted this cycle.
REQ-007 alloc_id  out  ROB  index of the granted entry.
REQ-008 done_valid  in  1  execution unit reports completion.
REQ-009 done_id  in  ROB  completed entry index.
REQ-010 done_exc  in  1  the completed instruction raised an exception.
REQ-011 commit_valid  out  1  head entry is ready to retire.
REQ-012 commit_id  out  ROB  head entry index.
REQ-013 commit_exc  out  1  head entry carries an exception.
REQ-014 commit_ready  in  1  retire stage accepts the head entry.
REQ-015 flush_req  in  1  external flush, such as a branch mispredict.
REQ-016 flush  out  1  flush in progress.
REQ-017 full / empty  out  1 / 1  occupancy flags.
REQ-018 count  out  ROB+1  number of occupied entries.

Function
REQ-019 Head and tail pointers shall each be ROB+1 bits wide, with the MSB acting as the wrap bit.
  - empty: head == tail.
  - full: index bits equal and wrap bits differ.
  - count: tail - head, modulo 2^(ROB+1).
REQ-020 The FSM shall have two states, RUN and FLUSH.
REQ-021 alloc_ack shall be combinational: alloc_req & !full & (state == RUN) & !flush_req.
  - alloc_id = tail[ROB-1:0].
  - The tail shall increment on the clock edge where alloc_ack is high.
REQ-022 An allocation shall clear done[tail] and exc[tail] on the same edge as the tail increment.
REQ-023 done_valid shall set done[done_id] and load exc[done_id] from done_exc on the next edge.
  - done_valid is ignored in FLUSH and for unoccupied indices.
  - A done for an entry already marked done overwrites exc.
REQ-024 commit_valid shall be combinational: !empty & done[head] & (state == RUN).
  - commit_id = head index; commit_exc = exc[head].
  - Latency from the done_valid edge to commit_valid is 1 cycle minimum.
REQ-025 When commit_valid & commit_ready, the head shall increment.
  - Committing with commit_exc = 1 shall also move the FSM to FLUSH.
REQ-026 A simultaneous alloc and commit shall leave count unchanged.
  - full blocks alloc even if a commit occurs in the same cycle; full is based on current state.
REQ-027 Pointers shall wrap from index ROB_DEPTH-1 to 0, toggling the wrap bit.
REQ-028 flush_req in RUN shall move the FSM to FLUSH on the next edge.
  - Pointers are not reset at that edge.
  - A commit handshake in the same cycle is honoured first.
REQ-029 In FLUSH, all of the following apply for exactly one cycle, then the FSM returns to RUN:
  - flush = 1, alloc_ack = 0, commit_valid = 0.
  - At the exit edge: head = tail = 0, all done and exc bits cleared.
REQ-030 A flush_req asserted during FLUSH shall be absorbed, with no extra FLUSH cycle.

Reset
REQ-031 On reset_ high, the block shall asynchronously enter this state:
  - FSM = RUN; head = tail = 0; all done and exc bits = 0.
  - Outputs: alloc_ack = 0, commit_valid = 0, commit_exc = 0, flush = 0, full = 0, empty = 1, count = 0, alloc_id = 0, commit_id = 0.
REQ-032 Reset asserted mid-flush or mid-handshake shall discard all state, and no commit shall be reported.

Configuration
REQ-033 Macro ROB_PERF_CNT_EN.
  - When defined: a 32-bit output perf_commit_cnt is added, reset to 0, incremented on each commit handshake, and wrapping at 2^32.
  - When undefined: the port and counter are absent, and all other behaviour is identical.

Verification (ROB_DEPTH = 4)
REQ-034 Fill: alloc_req held high for 5 cycles with no commits -> alloc_id 0, 1, 2, 3; acks only in the first 4 cycles; full = 1, count = 4.
REQ-035 Out-of-order done: done_id 2, then 0, then 1, with commit_ready = 1 -> commit_id sequence 0, 1, 2; commit_valid low while done[head] is clear.
REQ-036 Wrap: 6 alloc/commit pairs -> alloc_id sequence 0, 1, 2, 3, 0, 1; empty = 1 at the end; count never exceeds 4.
REQ-037 Exception: entry 1 done with done_exc = 1 -> commit 0, then commit 1 with commit_exc = 1; flush = 1 for one cycle; then count = 0 and the next alloc_id = 0.
REQ-038 flush_req together with alloc_req and a commit handshake -> alloc_ack = 0, the commit is taken, FLUSH follows, and pointers are 0 afterwards.
REQ-039 Reset asserted in FLUSH with 3 entries occupied -> empty = 1, flush = 0 immediately (asynchronous), with no clock edge required.
